// File: rtl/recover_2n_feed_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | recover_2n_feed_ctrl_if                                                    |
// | Source-buffer read and recovery-datapath handshake bundle.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface recover_2n_feed_ctrl_if #(
  parameter int ADDR_W = 13,
  parameter int IDX_W  = 11
);
  logic              src_avail;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_half;
  logic              dp_valid;
  logic [IDX_W-1:0]  dp_index_col_1;
  logic [IDX_W-1:0]  dp_index_col_2;
  logic              dp_ready;

  modport master (
    input  src_avail,
    input  dp_ready,
    output rd_en,
    output rd_addr,
    output rd_half,
    output dp_valid,
    output dp_index_col_1,
    output dp_index_col_2
  );

  modport slave (
    output src_avail,
    output dp_ready,
    input  rd_en,
    input  rd_addr,
    input  rd_half,
    input  dp_valid,
    input  dp_index_col_1,
    input  dp_index_col_2
  );
endinterface
`default_nettype wire

// File: rtl/recover_2n_feed_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | recover_2n_feed_ctrl                                                       |
// | Issues the 1025-beat input schedule to the 2N real-FFT recovery datapath.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module recover_2n_feed_ctrl #(
  parameter int NBEATS  = 1025,
  parameter int IDX_W   = 11,
  parameter int ADDR_W  = 13,
  parameter int RD_LAT  = 1,
  parameter int TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  recover_2n_feed_ctrl_if.master bus,
  output logic                  busy,
  output logic                  done,
  output logic                  err_timeout
);
  localparam int CNT_W = $clog2(NBEATS + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] C_LAST_BEAT = CNT_W'(NBEATS - 1);
  localparam logic [CNT_W-1:0] C_NBEATS    = CNT_W'(NBEATS);
  localparam logic [TO_W-1:0]  C_TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic [CNT_W-1:0]  ret_q, ret_d;
  logic [TO_W-1:0]   idle_q, idle_d;
  logic              err_q, err_d;
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [IDX_W-1:0]  col1_q [RD_LAT];
  logic [IDX_W-1:0]  col1_d [RD_LAT];
  logic [IDX_W-1:0]  col2_q [RD_LAT];
  logic [IDX_W-1:0]  col2_d [RD_LAT];

  logic              issue;
  logic [IDX_W-1:0]  nat1, nat2, rev1, rev2;
  logic [ADDR_W-1:0] addr;

  assign issue = (state_q == S_ISSUE) && bus.src_avail;

  // Beats 0/1 fetch half groups at 0 and 4; beat b>=2 fetches the full group at (b-1)*8.
  always_comb begin
    nat1 = IDX_W'(beat_q);
    nat2 = (beat_q < CNT_W'(2)) ? '0 : (IDX_W'(0) - nat1);
    addr = '0;
    if (beat_q == CNT_W'(1)) begin
      addr = ADDR_W'(4);
    end else if (beat_q >= CNT_W'(2)) begin
      addr = ADDR_W'({beat_q - 1'b1, 3'b000});
    end
  end

  for (genvar i = 0; i < IDX_W; i++) begin : g_bitrev
    assign rev1[i] = nat1[IDX_W-1-i];
    assign rev2[i] = nat2[IDX_W-1-i];
  end

  assign bus.rd_en          = issue;
  assign bus.rd_addr        = issue ? addr : '0;
  assign bus.rd_half        = issue && (beat_q < CNT_W'(2));
  assign bus.dp_valid       = vld_q[RD_LAT-1];
  assign bus.dp_index_col_1 = col1_q[RD_LAT-1];
  assign bus.dp_index_col_2 = col2_q[RD_LAT-1];

  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign err_timeout = err_q;

  // Index pipeline matches the source-buffer read latency so valid lines up with data.
  always_comb begin
    vld_d     = '0;
    col1_d    = '{default: '0};
    col2_d    = '{default: '0};
    vld_d[0]  = issue;
    col1_d[0] = issue ? rev1 : '0;
    col2_d[0] = issue ? rev2 : '0;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i]  = vld_q[i-1];
      col1_d[i] = col1_q[i-1];
      col2_d[i] = col2_q[i-1];
    end
  end

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    ret_d   = ret_q;
    idle_d  = idle_q;
    err_d   = err_q;

    if ((state_q != S_IDLE) && bus.dp_ready && (ret_q != C_NBEATS)) begin
      ret_d = ret_q + 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ISSUE;
          beat_d  = '0;
          ret_d   = '0;
          idle_d  = '0;
          err_d   = 1'b0;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          beat_d = beat_q + 1'b1;
          if (beat_q == C_LAST_BEAT) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // idle_q counts consecutive ready-low drain cycles; any ready activity restarts it.
        if ((ret_q == C_NBEATS) && !bus.dp_ready) begin
          state_d = S_DONE;
        end else if (bus.dp_ready) begin
          idle_d = '0;
        end else if (idle_q == C_TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          idle_d = idle_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      beat_q  <= '0;
      ret_q   <= '0;
      idle_q  <= '0;
      err_q   <= 1'b0;
      vld_q   <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        col1_q[i] <= '0;
        col2_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      ret_q   <= ret_d;
      idle_q  <= idle_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      for (int i = 0; i < RD_LAT; i++) begin
        col1_q[i] <= col1_d[i];
        col2_q[i] <= col2_d[i];
      end
    end
  end
endmodule
`default_nettype wire

// File: tb/tb_recover_2n_feed_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_recover_2n_feed_ctrl                                                    |
// | Directed bench for the recovery feed sequencer at RD_LAT=1 and RD_LAT=3.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_recover_2n_feed_ctrl;
  localparam int NB = 1025;
  localparam int IW = 11;
  localparam int AW = 13;
  localparam int TO = 16;

  logic clk       = 1'b0;
  logic rst_n     = 1'b1;
  logic start     = 1'b0;
  logic src_avail = 1'b0;
  logic mute      = 1'b0;
  logic rdy_a     = 1'b0;
  logic rdy_b     = 1'b0;
  logic busy_a, done_a, err_a;
  logic busy_b, done_b, err_b;

  always #5 clk = ~clk;

  recover_2n_feed_ctrl_if #(.ADDR_W(AW), .IDX_W(IW)) bus_a ();
  recover_2n_feed_ctrl_if #(.ADDR_W(AW), .IDX_W(IW)) bus_b ();

  assign bus_a.src_avail = src_avail;
  assign bus_a.dp_ready  = rdy_a;
  assign bus_b.src_avail = src_avail;
  assign bus_b.dp_ready  = rdy_b;

  recover_2n_feed_ctrl #(.NBEATS(NB), .IDX_W(IW), .ADDR_W(AW), .RD_LAT(1), .TIMEOUT(TO)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_a),
    .busy(busy_a), .done(done_a), .err_timeout(err_a)
  );

  recover_2n_feed_ctrl #(.NBEATS(NB), .IDX_W(IW), .ADDR_W(AW), .RD_LAT(3), .TIMEOUT(TO)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus_b),
    .busy(busy_b), .done(done_b), .err_timeout(err_b)
  );

  // Datapath model: returns each valid beat one cycle later unless muted.
  always @(posedge clk) begin
    rdy_a <= bus_a.dp_valid & ~mute;
    rdy_b <= bus_b.dp_valid & ~mute;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [IW-1:0] brev(input logic [IW-1:0] x);
    logic [IW-1:0] r;
    for (int i = 0; i < IW; i++) r[i] = x[IW-1-i];
    return r;
  endfunction

  function automatic logic [AW-1:0] exp_addr(input int b);
    int a;
    a = (b == 0) ? 0 : (b == 1) ? 4 : (b - 1) * 8;
    return AW'(a);
  endfunction

  function automatic logic [IW-1:0] exp_c1(input int b);
    return brev(IW'(b));
  endfunction

  function automatic logic [IW-1:0] exp_c2(input int b);
    return (b < 2) ? '0 : brev(IW'((2048 - b) % 2048));
  endfunction

  int          lat [2] = '{1, 3};
  logic        en_h [2][4];
  int          beat_h [2][4];
  int          eb [2], seq_err [2], lag_err [2], nvalid [2], run [2], maxrun [2];
  int          ndone [2], last_rden [2], last_valid [2], last_rdy [2], done_cyc [2];
  logic [AW-1:0] last_addr [2];
  logic [IW-1:0] c1_b1 [2], c1_b2 [2], c2_b2 [2];
  logic        dn_prev [2], busy_after [2];

  task automatic mon(input int d, input logic en, input logic half, input logic [AW-1:0] addr,
                     input logic vld, input logic [IW-1:0] c1, input logic [IW-1:0] c2,
                     input logic rdy, input logic dn, input logic bsy);
    int b;
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        en_h[d][k]   = 1'b0;
        beat_h[d][k] = 0;
      end
      eb[d] = 0; run[d] = 0; dn_prev[d] = 1'b0;
      return;
    end
    for (int k = 3; k > 0; k--) begin
      en_h[d][k]   = en_h[d][k-1];
      beat_h[d][k] = beat_h[d][k-1];
    end
    en_h[d][0]   = en;
    beat_h[d][0] = eb[d];
    if (en) begin
      if (addr !== exp_addr(eb[d]) || half !== (eb[d] < 2)) seq_err[d]++;
      last_addr[d] = addr;
      last_rden[d] = cyc;
      eb[d]++;
    end
    if (vld !== en_h[d][lat[d]]) lag_err[d]++;
    if (vld) begin
      b = beat_h[d][lat[d]];
      if (c1 !== exp_c1(b) || c2 !== exp_c2(b)) lag_err[d]++;
      if (b == 1) c1_b1[d] = c1;
      if (b == 2) begin c1_b2[d] = c1; c2_b2[d] = c2; end
      nvalid[d]++;
      run[d]++;
      if (run[d] > maxrun[d]) maxrun[d] = run[d];
      last_valid[d] = cyc;
    end else begin
      run[d] = 0;
    end
    if (rdy) last_rdy[d] = cyc;
    if (dn_prev[d]) busy_after[d] = bsy;
    if (dn) begin ndone[d]++; done_cyc[d] = cyc; end
    dn_prev[d] = dn;
  endtask

  always @(negedge clk) begin
    mon(0, bus_a.rd_en, bus_a.rd_half, bus_a.rd_addr, bus_a.dp_valid,
        bus_a.dp_index_col_1, bus_a.dp_index_col_2, rdy_a, done_a, busy_a);
    mon(1, bus_b.rd_en, bus_b.rd_half, bus_b.rd_addr, bus_b.dp_valid,
        bus_b.dp_index_col_1, bus_b.dp_index_col_2, rdy_b, done_b, busy_b);
  end

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      eb[d] = 0; seq_err[d] = 0; lag_err[d] = 0; nvalid[d] = 0; run[d] = 0; maxrun[d] = 0;
      ndone[d] = 0; last_rden[d] = 0; last_valid[d] = 0; last_rdy[d] = 0; done_cyc[d] = 0;
      last_addr[d] = '0; c1_b1[d] = '0; c1_b2[d] = '0; c2_b2[d] = '0; busy_after[d] = 1'b1;
    end
  endtask

  task automatic run_start();
    clear_stats();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!(ndone[0] > 0 && ndone[1] > 0) && n < 5000) begin
      @(posedge clk);
      n++;
    end
    check({tag, "_done_seen"}, 32'(n < 5000), 1);
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    for (int d = 0; d < 2; d++) dn_prev[d] = 1'b0;
    clear_stats();
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",   busy_a, 0);
    check("rst_done",   done_a, 0);
    check("rst_err",    err_a, 0);
    check("rst_rd_en",  bus_a.rd_en, 0);
    check("rst_rd_half", bus_a.rd_half, 0);
    check("rst_rd_addr", bus_a.rd_addr, 0);
    check("rst_valid",  bus_a.dp_valid, 0);
    check("rst_idx1",   bus_a.dp_index_col_1, 0);
    check("rst_idx2",   bus_a.dp_index_col_2, 0);
    check("rst_valid_b", bus_b.dp_valid, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame 1: continuous source, prompt datapath.
    src_avail = 1'b1;
    run_start();
    check("f1_busy", busy_a, 1);
    check("f1_first_rd_en", bus_a.rd_en, 1);
    wait_done("f1");
    check("f1_seq_err",   seq_err[0], 0);
    check("f1_beats",     eb[0], NB);
    check("f1_lag_err",   lag_err[0], 0);
    check("f1_nvalid",    nvalid[0], NB);
    check("f1_run",       maxrun[0], NB);
    check("f1_c1_b1",     c1_b1[0], 32'h400);
    check("f1_c1_b2",     c1_b2[0], 32'h200);
    check("f1_c2_b2",     c2_b2[0], 32'h3FF);
    check("f1_last_addr", last_addr[0], 8184);
    check("f1_ndone",     ndone[0], 1);
    check("f1_done_lag",  done_cyc[0] - last_rdy[0], 2);
    check("f1_busy_after", busy_after[0], 0);
    check("f1_err",       err_a, 0);
    check("f1b_lag_err",  lag_err[1], 0);
    check("f1b_nvalid",   nvalid[1], NB);
    check("f1b_last_lag", last_valid[1] - last_rden[1], 3);
    check("f1b_ndone",    ndone[1], 1);
    check("f1b_done_lag", done_cyc[1] - last_rdy[1], 2);

    // Frame 2: source availability toggles every three cycles.
    src_avail = 1'b1;
    run_start();
    fork
      begin
        for (int i = 0; i < 6000 && (busy_a || busy_b); i++) begin
          src_avail = ((i / 3) % 2) == 1;
          @(posedge clk);
          #1;
        end
        src_avail = 1'b1;
      end
    join_none
    wait_done("f2");
    check("f2_seq_err",  seq_err[0], 0);
    check("f2_beats",    eb[0], NB);
    check("f2_lag_err",  lag_err[0], 0);
    check("f2_nvalid",   nvalid[0], NB);
    check("f2_ndone",    ndone[0], 1);
    check("f2_err",      err_a, 0);
    check("f2b_lag_err", lag_err[1], 0);
    check("f2b_nvalid",  nvalid[1], NB);

    // Frame 3: datapath never returns, drain times out.
    src_avail = 1'b1;
    mute = 1'b1;
    run_start();
    wait_done("f3");
    check("f3_err",       err_a, 1);
    check("f3b_err",      err_b, 1);
    check("f3_ndone",     ndone[0], 1);
    check("f3_to_cycles", done_cyc[0] - last_rden[0], TO + 1);
    check("f3b_to_cycles", done_cyc[1] - last_rden[1], TO + 1);
    check("f3_nvalid",    nvalid[0], NB);
    mute = 1'b0;

    // Frame 4: new start clears the error, then reset lands mid-frame.
    run_start();
    check("f4_err_clr",  err_a, 0);
    check("f4b_err_clr", err_b, 0);
    n = 0;
    while (eb[0] < 500 && n < 2000) begin
      @(posedge clk);
      n++;
    end
    check("f4_reach_500", 32'(n < 2000), 1);
    #3 rst_n = 1'b0;
    #1;
    check("f4_rst_busy",  busy_a, 0);
    check("f4_rst_rd_en", bus_a.rd_en, 0);
    check("f4_rst_addr",  bus_a.rd_addr, 0);
    check("f4_rst_valid", bus_a.dp_valid, 0);
    check("f4_rst_valid_b", bus_b.dp_valid, 0);
    check("f4_rst_done",  done_a, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("f4_no_done", ndone[0], 0);

    // Frame 5: clean frame after the aborted one.
    run_start();
    wait_done("f5");
    check("f5_seq_err", seq_err[0], 0);
    check("f5_beats",   eb[0], NB);
    check("f5_nvalid",  nvalid[0], NB);
    check("f5_ndone",   ndone[0], 1);
    check("f5b_ndone",  ndone[1], 1);
    check("f5b_nvalid", nvalid[1], NB);
    check("f5_err",     err_a, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/recover_2n_feed_ctrl.md
Name: recover_2n_feed_ctrl

Overview:
- Frame sequencer in front of the 2N-point real-FFT recovery datapath (recover_2n_FFT).
- Reads the x1/x2 half-length CFFT results from the source buffers and issues the 1025-beat input schedule: beats 0–1 carry col1 only, beats 2..1024 carry col1 + col2.
- Drives the bit-reversed column indices and the datapath valid, then counts returned beats on the datapath ready.
- Reports frame done, or a drain timeout.

Parameters:
- NBEATS, 1025, input beats per frame (8192 points / 8 + 1).
- IDX_W, 11, column index width.
- ADDR_W, 13, source-buffer point address width.
- RD_LAT, 1, source-buffer read latency in cycles (1..4).
- TIMEOUT, 4096, maximum drain cycles without any ready activity before error.

Ports:
- clk, in, 1, clock.
- rst_n, in, 1, asynchronous active-low reset.
- start, in, 1, one-cycle frame request; ignored while busy=1.
- src_avail, in, 1, source buffers hold a full frame and may be read this cycle.
- rd_en, out, 1, source-buffer read strobe.
- rd_addr, out, ADDR_W, base point address of the 8-point (or 4-point) group.
- rd_half, out, 1, 1 = fetch col1 only (points rd_addr..+3).
- dp_valid, out, 1, datapath valid (recover_2n_FFT.valid).
- dp_index_col_1, out, IDX_W, bit-reversed col1 index.
- dp_index_col_2, out, IDX_W, bit-reversed col2 index.
- dp_ready, in, 1, datapath output-valid (recover_2n_FFT.ready).
- busy, out, 1, high from the accepted start until the done cycle, inclusive.
- done, out, 1, one-cycle frame-complete pulse.
- err_timeout, out, 1, sticky drain-timeout flag; cleared by the next accepted start.

Behaviour:
- Reset (async, rst_n=0): state=IDLE. rd_en, rd_half, dp_valid, busy, done, err_timeout=0. rd_addr=0, both indices=0. Beat and return counters=0.
- States: IDLE -> ISSUE -> DRAIN -> DONE -> IDLE.
- IDLE:
  - start=1 sets busy next cycle, clears both counters and err_timeout, goes to ISSUE.
- ISSUE:
  - Each cycle with src_avail=1, issue beat b (b = beat counter) with rd_en=1. If src_avail=0: rd_en=0 and b holds (bubble); the datapath tolerates valid gaps.
  - Beat 0: rd_addr=0, rd_half=1.
  - Beat 1: rd_addr=4, rd_half=1.
  - Beat b≥2: rd_addr=(b-1)*8, rd_half=0.
  - Natural indices: col1=b. col2=0 for b<2, else (2048-b) mod 2048.
  - Output indices are the 11-bit bit-reversals of the natural values (bit i -> bit 10-i).
  - dp_valid and both indices are the rd_en/index values delayed by exactly RD_LAT cycles through a shift pipeline, so they align with the read data.
  - After issuing beat NBEATS-1, go to DRAIN.
- Return counting (all states after start):
  - Every cycle with dp_ready=1 increments the return counter, saturating at NBEATS.
  - dp_ready=1 while in IDLE is ignored.
- DRAIN:
  - rd_en=0; the pipeline flushes its last valid.
  - Go to DONE when the return count reaches NBEATS and dp_ready=0 (falling edge seen or ready already low).
  - If TIMEOUT consecutive cycles pass with dp_ready=0 before the count completes, set err_timeout=1 and go to DONE.
- DONE: done=1 for exactly one cycle, busy still 1. Next state IDLE, busy=0.
- start coincident with done is ignored. start in IDLE with src_avail=0 is accepted; issue waits for src_avail.
- rst_n asserted mid-frame: immediate return to reset values. Pipeline contents are discarded, no done pulse.
- Address arithmetic is unsigned. Beat 1024 gives rd_addr=8184, the maximum. No wrap occurs within a frame.

Test Plan:
- Reset, start with src_avail=1 continuous, RD_LAT=1:
  - rd_addr sequence 0,4,8,16,…,8184.
  - dp_valid high for 1025 consecutive cycles, starting one cycle after the first rd_en.
  - dp_index_col_1 for b=1 is 0x400.
  - For b=2: col1=0x200, col2=bitrev(2046)=0x3FF.
- Model datapath asserts dp_ready for 1025 cycles then drops it -> one done pulse 1 cycle after the drop, busy=0 on the next cycle, err_timeout=0.
- src_avail toggles 0/1 every 3 cycles during ISSUE -> beats never skipped or repeated, dp_valid gaps match the src_avail gaps shifted by RD_LAT, total 1025 valid beats.
- RD_LAT=3 -> dp_valid and indices lag rd_en by exactly 3 cycles. Last valid 3 cycles after the last rd_en.
- dp_ready held 0 after issue, TIMEOUT=16 -> err_timeout=1 and done pulse after 16 idle drain cycles. Next start clears err_timeout.
- rst_n pulled low at beat 500, then a new start -> all outputs reset asynchronously. The new frame starts at rd_addr=0 with 1025 beats and a single done.
